// File: rtl/fdl_pkg.sv
// Shared types and helpers for the FDL tuning controller.
package fdl_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    localparam int FDL_FINE_BITS_DEF   = 6;
    localparam int FDL_COARSE_BITS_DEF = 4;
    localparam int FDL_THERM_MAX       = 32;

    // MSB-first thermometer: level k sets bits [width-1 : width-k]; caller truncates to width.
    function automatic logic [FDL_THERM_MAX-1:0] therm_of(input int level, input int width);
        logic [FDL_THERM_MAX-1:0] t;
        t = '0;
        for (int i = 0; i < FDL_THERM_MAX; i++)
            if (i < width && i >= width - level)
                t[i] = 1'b1;
        return t;
    endfunction

endpackage

// File: rtl/fdl_vote_filter.sv
// Signed up/down vote accumulator; emits a combinational one-cycle step pulse with
// direction when the accumulator would reach the threshold on this edge.
module fdl_vote_filter
    import fdl_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic en,
    input  logic pd_up,
    input  logic pd_dn,
    input  logic dbl_thr,
    output logic step,
    output dir_t step_dir
);
    localparam int ACC_W = 7;
    localparam logic signed [ACC_W-1:0] THR1 = ACC_W'(FILTER_LEN);
    localparam logic signed [ACC_W-1:0] THR2 = ACC_W'(2 * FILTER_LEN);

    logic signed [ACC_W-1:0] acc, acc_sum, vote, thr;

    always_comb begin
        vote     = '0;
        step     = 1'b0;
        step_dir = DIR_NONE;
        thr      = dbl_thr ? THR2 : THR1;
        if (pd_up && !pd_dn)
            vote = ACC_W'(1);
        else if (pd_dn && !pd_up)
            vote = -ACC_W'(1);
        acc_sum = acc + vote;
        // Magnitude compare so a threshold that drops while acc is above it still fires.
        if (en) begin
            if (acc_sum >= thr) begin
                step     = 1'b1;
                step_dir = DIR_UP;
            end else if (acc_sum <= -thr) begin
                step     = 1'b1;
                step_dir = DIR_DN;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n)
            acc <= '0;
        else if (en)
            acc <= step ? '0 : acc_sum;
    end

endmodule

// File: rtl/fdl_tune_ctrl.sv
// FDL tuning controller: filtered fine thermometer stepping with coarse carry/borrow,
// saturation flags and alternation-based lock. Optional macro FDL_LOCK_FREEZE_EN.
module fdl_tune_ctrl
    import fdl_pkg::*;
#(
    parameter int FINE_BITS   = FDL_FINE_BITS_DEF,
    parameter int COARSE_BITS = FDL_COARSE_BITS_DEF,
    parameter int FILTER_LEN  = 4,
    parameter int LOCK_CNT    = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   pd_up,
    input  logic                   pd_dn,
    output logic [FINE_BITS-1:0]   fine_q,
    output logic [FINE_BITS:0]     fine_onehot,
    output logic [COARSE_BITS-1:0] coarse_sel,
    output logic                   at_min,
    output logic                   at_max,
    output logic                   locked
);
    localparam int FL_W  = $clog2(FINE_BITS + 1);
    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [FL_W-1:0]  FINE_MAX = FL_W'(FINE_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_CNT);

    logic                   step, dbl_thr;
    dir_t                   step_dir, last_dir, last_nxt;
    logic [FL_W-1:0]        fine_lvl, fine_nxt;
    logic [COARSE_BITS-1:0] coarse_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;

`ifdef FDL_LOCK_FREEZE_EN
    assign dbl_thr = locked;
`else
    assign dbl_thr = 1'b0;
`endif

    fdl_vote_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .pd_up    (pd_up),
        .pd_dn    (pd_dn),
        .dbl_thr  (dbl_thr),
        .step     (step),
        .step_dir (step_dir)
    );

    always_comb begin
        fine_nxt   = fine_lvl;
        coarse_nxt = coarse_sel;
        cnt_nxt    = cnt;
        last_nxt   = last_dir;
        if (!en) begin
            cnt_nxt = '0;
        end else if (step) begin
            if (step_dir == DIR_UP) begin
                if (fine_lvl < FINE_MAX) begin
                    fine_nxt = fine_lvl + 1'b1;
                end else if (coarse_sel != '1) begin
                    coarse_nxt = coarse_sel + 1'b1;
                    fine_nxt   = '0;
                end
            end else begin
                if (fine_lvl != '0) begin
                    fine_nxt = fine_lvl - 1'b1;
                end else if (coarse_sel != '0) begin
                    coarse_nxt = coarse_sel - 1'b1;
                    fine_nxt   = FINE_MAX;
                end
            end
            // Saturated steps still count; the first step after reset has no reference.
            if (last_dir == step_dir)
                cnt_nxt = '0;
            else if (last_dir != DIR_NONE && cnt != CNT_MAX)
                cnt_nxt = cnt + 1'b1;
`ifdef FDL_LOCK_FREEZE_EN
            if (locked)
                cnt_nxt = '0;
`endif
            last_nxt = step_dir;
        end
    end

    // Outputs are registered decodes of the next-state values, so they never disagree.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            fine_lvl    <= '0;
            coarse_sel  <= '0;
            cnt         <= '0;
            last_dir    <= DIR_NONE;
            fine_q      <= '0;
            fine_onehot <= (FINE_BITS+1)'(1);
            at_min      <= 1'b1;
            at_max      <= 1'b0;
            locked      <= 1'b0;
        end else begin
            fine_lvl    <= fine_nxt;
            coarse_sel  <= coarse_nxt;
            cnt         <= cnt_nxt;
            last_dir    <= last_nxt;
            fine_q      <= FINE_BITS'(therm_of(int'(fine_nxt), FINE_BITS));
            fine_onehot <= (FINE_BITS+1)'(1) << fine_nxt;
            at_min      <= (fine_nxt == '0) && (coarse_nxt == '0);
            at_max      <= (fine_nxt == FINE_MAX) && (coarse_nxt == '1);
            locked      <= (cnt_nxt == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_fdl_tune_ctrl.sv
// Directed bench for fdl_tune_ctrl with default parameters (6/4/4/8).
module tb_fdl_tune_ctrl;
    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       en     = 1'b1;
    logic       pd_up  = 1'b0;
    logic       pd_dn  = 1'b0;
    logic [5:0] fine_q;
    logic [6:0] fine_onehot;
    logic [3:0] coarse_sel;
    logic       at_min, at_max, locked;

    int checks   = 0;
    int failures = 0;
    int lvl;

    fdl_tune_ctrl #(
        .FINE_BITS(6), .COARSE_BITS(4), .FILTER_LEN(4), .LOCK_CNT(8)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .en          (en),
        .pd_up       (pd_up),
        .pd_dn       (pd_dn),
        .fine_q      (fine_q),
        .fine_onehot (fine_onehot),
        .coarse_sel  (coarse_sel),
        .at_min      (at_min),
        .at_max      (at_max),
        .locked      (locked)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] th(input int k);
        logic [5:0] t;
        t = '0;
        for (int i = 0; i < 6; i++)
            if (i >= 6 - k) t[i] = 1'b1;
        return t;
    endfunction

    // n cycles of the given vote, then inputs released; returns on a negedge.
    task automatic votes(input logic u, input logic d, input int n);
        repeat (n) begin
            @(negedge clk_in);
            pd_up = u;
            pd_dn = d;
        end
        @(negedge clk_in);
        pd_up = 1'b0;
        pd_dn = 1'b0;
    endtask

    task automatic chk_code(input string tag, input int k, input int c);
        chk({tag, "_q"},  32'(fine_q),      32'(th(k)));
        chk({tag, "_oh"}, 32'(fine_onehot), 32'(7'd1 << k));
        chk({tag, "_cs"}, 32'(coarse_sel),  32'(c));
    endtask

    task automatic chk_reset(input string tag);
        chk_code(tag, 0, 0);
        chk({tag, "_min"}, 32'(at_min), 32'd1);
        chk({tag, "_max"}, 32'(at_max), 32'd0);
        chk({tag, "_lk"},  32'(locked), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk_in);
        rst_n = 1'b0;
        @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk_in);
        chk_reset("reset");
        rst_n = 1'b1;

        votes(1, 0, 3);  chk_code("pre_step", 0, 0);
        votes(1, 0, 1);  chk_code("first_up", 1, 0);
        votes(1, 0, 3);  chk_code("acc_clr", 1, 0);
        votes(1, 0, 17); chk_code("fine_full", 6, 0);
        votes(1, 0, 4);  chk_code("carry", 0, 1);
        chk("carry_min", 32'(at_min), 32'd0);

        votes(0, 1, 4);  chk_code("borrow", 6, 0);
        votes(0, 1, 24); chk_code("to_min", 0, 0);
        chk("to_min_flag", 32'(at_min), 32'd1);
        votes(0, 1, 4);  chk_code("sat_min", 0, 0);
        chk("sat_min_flag", 32'(at_min), 32'd1);

        // Nine alternating steps from reset, first one saturating DN.
        pulse_reset();
        for (int i = 1; i <= 9; i++) begin
            votes(i % 2 == 0, i % 2 == 1, 4);
            if (i == 8) chk("lock_8", 32'(locked), 32'd0);
        end
        chk("lock_9", 32'(locked), 32'd1);
        chk_code("lock_9", 0, 0);

`ifdef FDL_LOCK_FREEZE_EN
        votes(1, 0, 4); chk_code("frz_hold", 0, 0);
        chk("frz_hold_lk", 32'(locked), 32'd1);
        votes(1, 0, 4); chk_code("frz_step", 1, 0);
        chk("frz_step_lk", 32'(locked), 32'd0);
        lvl = 1;
`else
        votes(1, 0, 4); chk_code("alt_sat", 1, 0);
        chk("alt_sat_lk", 32'(locked), 32'd1);
        votes(1, 0, 4); chk_code("same_dir", 2, 0);
        chk("same_dir_lk", 32'(locked), 32'd0);
        lvl = 2;
`endif

        for (int i = 1; i <= 8; i++)
            votes(i % 2 == 0, i % 2 == 1, 4);
        chk("relock", 32'(locked), 32'd1);
        chk_code("relock", lvl, 0);

        votes(1, 0, 3);
        chk("pre_en_lk", 32'(locked), 32'd1);
        @(negedge clk_in);
        en    = 1'b0;
        pd_up = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("en_off_lk", 32'(locked), 32'd0);
        chk_code("en_off", lvl, 0);
        pd_up = 1'b0;
        en    = 1'b1;
        votes(1, 0, 1);
        chk_code("en_resume", lvl + 1, 0);

        votes(1, 1, 20); chk_code("both", lvl + 1, 0);

        votes(1, 0, 2);
        pulse_reset();
        chk_reset("mid_reset");
        votes(1, 0, 2);  chk_code("post_reset", 0, 0);
        votes(1, 0, 444); chk_code("to_max", 6, 15);
        chk("to_max_flag", 32'(at_max), 32'd1);
        votes(1, 0, 4);  chk_code("sat_max", 6, 15);
        chk("sat_max_flag", 32'(at_max), 32'd1);
        chk("sat_max_min", 32'(at_min), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fdl_tune_ctrl.md
Name: fdl_tune_ctrl

Overview:
- Digital tuning controller for the fine delay line (FDL) inside the FMDLL loop.
- Filters phase-detector up/down pulses and steps a parametrised thermometer fine code.
- Carries and borrows into a coarse delay-select counter when the fine range is exhausted.
- Reports saturation and lock, replacing the hand-driven static 6-bit Q of the previous generation.

Parameters:
- FINE_BITS, 6: fine thermometer width; fine level range 0..FINE_BITS.
- COARSE_BITS, 4: coarse select width; coarse range 0..2^COARSE_BITS-1.
- FILTER_LEN, 4: net up/down votes needed per step, in the range 2..15.
- LOCK_CNT, 8: consecutive direction-alternating steps needed to assert locked.

Ports:
- clk_in input 1: loop reference clock; all state updates on rising edge.
- rst_n input 1: synchronous active-low reset.
- en input 1: when low, filter and code are held; lock counter is cleared.
- pd_up input 1: phase detector vote for more delay, sampled each cycle.
- pd_dn input 1: phase detector vote for less delay, sampled each cycle.
- fine_q output FINE_BITS: thermometer code, MSB-first fill (level k sets the top k bits, e.g. 3 gives 111000 for width 6).
- fine_onehot output FINE_BITS+1: one-hot of the fine level; bit k is set when the level is k.
- coarse_sel output COARSE_BITS: coarse delay tap index.
- at_min output 1: fine level is 0 and coarse is 0.
- at_max output 1: fine level is FINE_BITS and coarse is at its maximum.
- locked output 1: loop lock indication.

Behaviour:
- Reset (rst_n=0 at an edge):
  - fine level 0, so fine_q=0 and fine_onehot=1.
  - coarse_sel=0, at_min=1, at_max=0, locked=0.
  - Filter accumulator 0, lock counter 0, last-direction cleared.
- Reset mid-step discards any pending step. All outputs are registered.
- Filter: signed accumulator.
  - pd_up&!pd_dn adds 1; pd_dn&!pd_up subtracts 1; both or neither hold.
  - Inputs are ignored while en=0.
- Step generation, on the edge where the accumulator would reach +FILTER_LEN:
  - An UP step is taken and the accumulator is loaded with 0 on that same edge.
  - -FILTER_LEN gives a DOWN step in the same way.
  - Latency: the code changes on the same edge that registers the threshold vote, one cycle after the vote is presented.
- UP step:
  - If fine level < FINE_BITS: fine+1.
  - Else if coarse < max: coarse+1 and fine=0 (carry).
  - Else saturate: no change; the accumulator is still cleared.
- DOWN step:
  - If fine level > 0: fine-1.
  - Else if coarse > 0: coarse-1 and fine=FINE_BITS (borrow).
  - Else saturate.
- A saturated step counts as a step for lock purposes, with its direction.
- Lock tracking:
  - A step opposite in direction to the previous step increments the lock counter (saturating at LOCK_CNT).
  - A step in the same direction clears the counter and deasserts locked.
  - locked=1 while the counter equals LOCK_CNT. It asserts on the edge of the LOCK_CNT-th alternation.
  - en=0 clears the counter and locked on the next edge.
- fine_q and fine_onehot are always consistent decodes of the single fine-level register. No illegal thermometer patterns may appear.

Optional Feature:
- Macro FDL_LOCK_FREEZE_EN.
- When defined: while locked=1, step thresholds become ±2*FILTER_LEN.
  - A step taken while locked unconditionally clears locked and the counter.
  - Thresholds revert to ±FILTER_LEN on the next cycle.
- When undefined: thresholds are always ±FILTER_LEN and lock behaves as above.

Decomposition:
- Shared package fdl_pkg holds:
  - typedef dir_t {DIR_NONE, DIR_UP, DIR_DN}.
  - Default width constants FDL_FINE_BITS_DEF=6 and FDL_COARSE_BITS_DEF=4.
  - Function therm_of(level) returning the MSB-first thermometer.
- One sub-module, fdl_vote_filter: the accumulator plus threshold compare, emitting a one-cycle step pulse with dir_t.
- The parent holds the fine/coarse counters, decode and lock logic.

Test Plan:
- Reset, then pd_up=1 for 4 cycles (FILTER_LEN=4) -> fine_q=100000 and fine_onehot=0000010 on the 4th edge; accumulator back at 0.
- 28 up-votes from reset -> fine reaches 111111 after 24 votes; the 28th vote gives coarse_sel=1 and fine_q=000000 (carry).
- From coarse=1 and fine=0, 4 down-votes -> coarse_sel=0, fine_q=111111 (borrow). A further 24 down-votes reach at_min=1; 4 more leave all outputs unchanged.
- Alternate 4 up-votes and 4 down-votes for 9 steps with LOCK_CNT=8 -> locked rises on the 9th step edge. Then two consecutive UP steps -> locked falls on the second.
- pd_up=pd_dn=1 for 20 cycles -> no code change. Toggle en=0 mid-filter with 3 up-votes accumulated -> code held and locked=0; rst_n=0 for one edge -> all reset values.
- With FDL_LOCK_FREEZE_EN and locked=1: 4 up-votes -> no step; 8 up-votes -> one step and locked=0.
